// File: rtl/mux4_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundle between the requesters and the round-robin arbiter that drives the
// MUX_4 select input.
//   req    [3:0] : request vector, bit i = requester i, level-held
//   grant  [3:0] : one-hot grant, all zero when idle
//   select [1:0] : index of current/last owner, drives the MUX_4 select
//   busy         : high while any grant is active
//   lock         : (ARB_LOCK_EN only) owner asks to keep the mux past MAX_HOLD
// Modports: master = requester side, slave = arbiter side.
// Optional feature macro: ARB_LOCK_EN
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  modport master (
    output req,
    input  grant,
    input  select,
    input  busy
`ifdef ARB_LOCK_EN
    ,
    output lock
`endif
  );

  modport slave (
    input  req,
    output grant,
    output select,
    output busy
`ifdef ARB_LOCK_EN
    ,
    input  lock
`endif
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing the 4:1 MUX_4 datapath between four
// requesters. Each owner keeps the grant for at most MAX_HOLD cycles; at a
// release point the next requester after the owner wins on the same edge.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : mux4_rr_arbiter_if.slave (req in; grant/select/busy out;
//           lock in when ARB_LOCK_EN is defined)
// Parameters:
//   MAX_HOLD : maximum consecutive cycles for one owner (>= 1)
//   CNT_W    : hold counter width, must hold MAX_HOLD-1
// Optional feature macro: ARB_LOCK_EN (owner lock suppresses MAX_HOLD expiry)
// All outputs are registered.
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  mux4_rr_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // Returns {found, index}: first set request scanning ptr+1, ptr+2, ptr+3, ptr.
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] i_req, input logic [1:0] i_ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = i_ptr + 2'(k);
      if (i_req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t           r_state,    w_state;
  logic [3:0]       r_grant,    w_grant;
  logic [1:0]       r_select,   w_select;
  logic             r_busy,     w_busy;
  logic [1:0]       r_ptr,      w_ptr;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt;

  logic [2:0]       w_pick;
  logic             w_owner_req;
  logic             w_lock_hold;
  logic             w_at_last;
  logic             w_release;

  // Next-state and next-output decode for the arbitration FSM.
  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_select   = r_select;
    w_busy     = r_busy;
    w_ptr      = r_ptr;
    w_hold_cnt = r_hold_cnt;

    // In GRANT the pointer is the owner, so searching from it gives priority
    // to every other requester and re-grants the owner only if it is alone.
    // A dropped owner request is already 0, so no extra masking is needed.
    w_pick      = rr_pick(bus.req, r_ptr);
    w_owner_req = bus.req[r_ptr];
`ifdef ARB_LOCK_EN
    w_lock_hold = bus.lock & w_owner_req;
`else
    w_lock_hold = 1'b0;
`endif
    w_at_last = (r_hold_cnt == HOLD_LAST);
    w_release = (~w_owner_req) | (w_at_last & ~w_lock_hold);

    case (r_state)
      ST_IDLE: begin
        if (w_pick[2]) begin
          w_state    = ST_GRANT;
          w_grant    = 4'b0001 << w_pick[1:0];
          w_select   = w_pick[1:0];
          w_busy     = 1'b1;
          w_ptr      = w_pick[1:0];
          w_hold_cnt = '0;
        end else begin
          w_state  = ST_IDLE;
          w_grant  = 4'b0000;
          w_busy   = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!w_release) begin
          // Saturate while a lock keeps the owner past its last hold cycle.
          if (!w_at_last) begin
            w_hold_cnt = r_hold_cnt + CNT_W'(1);
          end else begin
            w_hold_cnt = r_hold_cnt;
          end
        end else if (w_pick[2]) begin
          w_state    = ST_GRANT;
          w_grant    = 4'b0001 << w_pick[1:0];
          w_select   = w_pick[1:0];
          w_busy     = 1'b1;
          w_ptr      = w_pick[1:0];
          w_hold_cnt = '0;
        end else begin
          // select keeps the last owner so the mux input does not glitch.
          w_state    = ST_IDLE;
          w_grant    = 4'b0000;
          w_busy     = 1'b0;
          w_hold_cnt = '0;
        end
      end
      default: begin
        w_state    = ST_IDLE;
        w_grant    = 4'b0000;
        w_busy     = 1'b0;
        w_hold_cnt = '0;
      end
    endcase
  end

  // State and output registers; ptr resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= 4'b0000;
      r_select   <= 2'b00;
      r_busy     <= 1'b0;
      r_ptr      <= 2'd3;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_grant    <= w_grant;
      r_select   <= w_select;
      r_busy     <= w_busy;
      r_ptr      <= w_ptr;
      r_hold_cnt <= w_hold_cnt;
    end
  end

  assign bus.grant  = r_grant;
  assign bus.select = r_select;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mux4_rr_arbiter_if if_a ();
  mux4_rr_arbiter_if if_b ();

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    int         reps;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
    chk({name, ".grant"},  if_a.grant, g);
    chk({name, ".select"}, {2'b00, if_a.select}, {2'b00, s});
    chk({name, ".busy"},   {3'b000, if_a.busy}, {3'b000, b});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    if_a.req = 4'b0000;
    if_b.req = 4'b0000;
`ifdef ARB_LOCK_EN
    if_a.lock = 1'b0;
    if_b.lock = 1'b0;
`endif

    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 0};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 6};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 2};
    vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 4};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 4};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 4};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 4};
    vecs[8]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 2};
    vecs[9]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 2};
    vecs[10] = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, 1};
    vecs[11] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1};
    vecs[12] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 2};

    @(posedge clk);
    #1;

    // Table-driven run on the MAX_HOLD=4 instance.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) begin
        if_a.req = vecs[i].req;
        reset = 1'b1;
        #1;
        chk_a($sformatf("vec%0d_rst", i), vecs[i].g, vecs[i].s, vecs[i].b);
        #2;
        reset = 1'b0;
      end else begin
        if_a.req = vecs[i].req;
        for (int r = 0; r < vecs[i].reps; r++) begin
          tick();
          chk_a($sformatf("vec%0d_c%0d", i, r), vecs[i].g, vecs[i].s, vecs[i].b);
        end
      end
    end

    // Async reset between edges while requester 2 owns the mux.
    do_reset();
    if_a.req = 4'b0100;
    tick();
    chk_a("own2", 4'b0100, 2'd2, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk_a("async_rst", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    if_a.req = 4'b0101;
    tick();
    chk_a("post_rst_prio", 4'b0001, 2'd0, 1'b1);

    // A non-owner pulse that drops before the release point is lost.
    if_a.req = 4'b0011;
    tick();
    if_a.req = 4'b0001;
    tick();
    tick();
    tick();
    chk_a("pulse_lost", 4'b0001, 2'd0, 1'b1);
    if_a.req = 4'b0000;
    tick();
    chk_a("pulse_idle", 4'b0000, 2'd0, 1'b0);

    // MAX_HOLD=1: grant rotates every cycle between active requesters.
    do_reset();
    if_b.req = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("mh1_c%0d.grant", c), if_b.grant, (c % 2 == 0) ? 4'b0001 : 4'b0100);
      chk($sformatf("mh1_c%0d.busy", c), {3'b000, if_b.busy}, 4'b0001);
    end
    if_b.req = 4'b0000;
    tick();
    chk("mh1_idle.grant", if_b.grant, 4'b0000);
    chk("mh1_idle.select", {2'b00, if_b.select}, 4'b0010);

`ifdef ARB_LOCK_EN
    // Lock keeps owner 2 past MAX_HOLD; releasing lock hands over to 0.
    do_reset();
    if_a.req = 4'b0100;
    tick();
    chk_a("lock_own", 4'b0100, 2'd2, 1'b1);
    if_a.req  = 4'b0101;
    if_a.lock = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_a($sformatf("lock_c%0d", c), 4'b0100, 2'd2, 1'b1);
    end
    if_a.lock = 1'b0;
    tick();
    chk_a("lock_release", 4'b0001, 2'd0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
